// File: rtl/board_pkg.sv
// Cell codes, colour table and fetch FSM states shared by the board display scheduler.
package board_pkg;

   typedef logic [2:0] cell_code_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fsm_state_e;

   localparam logic [23:0] EMPTY_COLOUR = 24'h202020;
   localparam logic [23:0] BG_COLOUR    = 24'h102040;

   localparam logic [23:0] PALETTE [8] = '{
      EMPTY_COLOUR, 24'h00FFFF, 24'hFFFF00, 24'h800080,
      24'h00FF00,   24'hFF0000, 24'h0000FF, 24'hFF8000
   };

   function automatic logic [23:0] palette_lookup(input cell_code_t code);
      return PALETTE[code];
   endfunction

endpackage

// File: rtl/board_display_scheduler_if.sv
// Game-logic request port into the board RAM: valid/ready request plus read-return.
interface board_display_scheduler_if #(
   parameter int addr_w_p = 8
);
   import board_pkg::*;

   logic                game_v;
   logic                game_ready;
   logic                game_we;
   logic [addr_w_p-1:0] game_addr;
   cell_code_t          game_wdata;
   cell_code_t          game_rdata;
   logic                game_rdata_v;

   modport master (
      output game_v, game_we, game_addr, game_wdata,
      input  game_ready, game_rdata, game_rdata_v
   );

   modport slave (
      input  game_v, game_we, game_addr, game_wdata,
      output game_ready, game_rdata, game_rdata_v
   );
endinterface

// File: rtl/board_line_buffer.sv
// One board row of cell codes; cleared on reset, written by the fetch, read by the pixel path.
module board_line_buffer
   import board_pkg::*;
#(
   parameter int depth_p = 10,
   parameter int idx_w_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               we_i,
   input  logic [idx_w_p-1:0] waddr_i,
   input  cell_code_t         wdata_i,
   input  logic [idx_w_p-1:0] raddr_i,
   output cell_code_t         rdata_o
);

   cell_code_t mem_q [depth_p];

   // Row storage update.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < depth_p; i++) begin
         if (reset_i) begin
            mem_q[i] <= 3'd0;
         end else if (we_i && (waddr_i == idx_w_p'(i))) begin
            mem_q[i] <= wdata_i;
         end
      end
   end

   // Indices past the row read as empty.
   always_comb begin
      rdata_o = 3'd0;
      if (32'(raddr_i) < 32'(depth_p)) begin
         rdata_o = mem_q[raddr_i];
      end else begin
         rdata_o = 3'd0;
      end
   end

endmodule

// File: rtl/board_display_scheduler.sv
// Shares the board RAM between a per-line display fetch (priority) and the game port,
// and turns VGA pixel coordinates into board colours with one cycle of latency.
module board_display_scheduler
   import board_pkg::*;
#(
   parameter int width_p     = 800,
   parameter int height_p    = 600,
   parameter int board_w_p   = 10,
   parameter int board_h_p   = 20,
   parameter int cell_px_p   = 16,
   parameter int board_x0_p  = 320,
   parameter int board_y0_p  = 140,
   parameter int bit_depth_p = 8
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   input  logic [$clog2(width_p)-1:0]                x_i,
   input  logic [$clog2(height_p)-1:0]               y_i,
   input  logic                                      xy_v_i,
   output logic [bit_depth_p-1:0]                    r_o,
   output logic [bit_depth_p-1:0]                    g_o,
   output logic [bit_depth_p-1:0]                    b_o,
   output logic [$clog2(board_w_p*board_h_p)-1:0]    ram_addr_o,
   output logic                                      ram_we_o,
   output cell_code_t                                ram_wdata_o,
   input  cell_code_t                                ram_rdata_i,
   board_display_scheduler_if.slave                  game_if
);

   localparam int YW    = $clog2(height_p);
   localparam int AW    = $clog2(board_w_p*board_h_p);
   localparam int CW    = $clog2(board_w_p);
   localparam int SH    = $clog2(cell_px_p);
   localparam int CELLS = board_w_p*board_h_p;
   localparam int BX1   = board_x0_p + board_w_p*cell_px_p;
   localparam int BY1   = board_y0_p + board_h_p*cell_px_p;

   fsm_state_e       state_q, state_d;
   logic             xy_v_q;
   logic [YW-1:0]    last_y_q, last_y_d;
   logic [AW-1:0]    row_q, row_d;
   logic [CW-1:0]    col_q, col_d;
   logic             cap_v_q, cap_v_d;
   logic [CW-1:0]    cap_col_q, cap_col_d;
   logic             lib_q, lib_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_oob_q, rd_oob_d;
   logic [bit_depth_p-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

   logic             trigger_s, tgt_in_s, game_oob_s, accept_s, px_in_s;
   logic [YW-1:0]    tgt_s;
   logic [CW-1:0]    px_col_s;
   cell_code_t       buf_rdata_s;
   logic [23:0]      rgb_s;

   board_line_buffer #(.depth_p(board_w_p), .idx_w_p(CW)) u_buf (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .we_i    (cap_v_q),
      .waddr_i (cap_col_q),
      .wdata_i (ram_rdata_i),
      .raddr_i (px_col_s),
      .rdata_o (buf_rdata_s)
   );

   assign trigger_s  = xy_v_q & ~xy_v_i;
   assign tgt_s      = (last_y_q == YW'(height_p-1)) ? {YW{1'b0}} : last_y_q + YW'(1);
   assign tgt_in_s   = (32'(tgt_s) >= 32'(board_y0_p)) && (32'(tgt_s) < 32'(BY1));
   assign game_oob_s = 32'(game_if.game_addr) >= 32'(CELLS);
   assign game_if.game_ready = (state_q == IDLE) & ~trigger_s & ~reset_i;
   assign accept_s   = game_if.game_ready & game_if.game_v;
   assign game_if.game_rdata_v = rd_pend_q;
   assign game_if.game_rdata   = (rd_pend_q & ~rd_oob_q) ? ram_rdata_i : 3'd0;
   assign px_in_s    = (32'(x_i) >= 32'(board_x0_p)) && (32'(x_i) < 32'(BX1));
   assign px_col_s   = CW'((32'(x_i) - 32'(board_x0_p)) >> SH);

   // Fetch FSM next state and RAM port mux; the display side owns the RAM outside IDLE.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      cap_v_d     = 1'b0;
      cap_col_d   = col_q;
      lib_d       = lib_q;
      rd_pend_d   = 1'b0;
      rd_oob_d    = 1'b0;
      last_y_d    = xy_v_i ? y_i : last_y_q;
      ram_addr_o  = {AW{1'b0}};
      ram_we_o    = 1'b0;
      ram_wdata_o = game_if.game_wdata;
      if (reset_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger_s) begin
                  if (tgt_in_s) begin
                     state_d = FETCH;
                     row_d   = AW'((32'(tgt_s) - 32'(board_y0_p)) >> SH);
                     col_d   = {CW{1'b0}};
                  end else begin
                     lib_d = 1'b0;
                  end
               end else if (accept_s) begin
                  ram_addr_o = game_if.game_addr;
                  ram_we_o   = game_if.game_we & ~game_oob_s;
                  rd_pend_d  = ~game_if.game_we;
                  rd_oob_d   = game_oob_s;
               end else begin
                  state_d = IDLE;
               end
            end
            FETCH: begin
               ram_addr_o = AW'(32'(row_q)*32'(board_w_p) + 32'(col_q));
               cap_v_d    = 1'b1;
               cap_col_d  = col_q;
               if (col_q == CW'(board_w_p-1)) begin
                  state_d = DRAIN;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
            DRAIN: begin
               lib_d   = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Pixel colour selection ahead of the output register.
   always_comb begin
      rgb_s = 24'h000000;
      if (!xy_v_i) begin
         rgb_s = 24'h000000;
      end else if (lib_q && px_in_s) begin
         rgb_s = palette_lookup(buf_rdata_s);
      end else begin
         rgb_s = BG_COLOUR;
      end
      r_d = bit_depth_p'(rgb_s[23:16]);
      g_d = bit_depth_p'(rgb_s[15:8]);
      b_d = bit_depth_p'(rgb_s[7:0]);
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         xy_v_q    <= 1'b0;
         last_y_q  <= {YW{1'b0}};
         row_q     <= {AW{1'b0}};
         col_q     <= {CW{1'b0}};
         cap_v_q   <= 1'b0;
         cap_col_q <= {CW{1'b0}};
         lib_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_oob_q  <= 1'b0;
         r_q       <= {bit_depth_p{1'b0}};
         g_q       <= {bit_depth_p{1'b0}};
         b_q       <= {bit_depth_p{1'b0}};
      end else begin
         state_q   <= state_d;
         xy_v_q    <= xy_v_i;
         last_y_q  <= last_y_d;
         row_q     <= row_d;
         col_q     <= col_d;
         cap_v_q   <= cap_v_d;
         cap_col_q <= cap_col_d;
         lib_q     <= lib_d;
         rd_pend_q <= rd_pend_d;
         rd_oob_q  <= rd_oob_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign r_o = r_q;
   assign g_o = g_q;
   assign b_o = b_q;

endmodule

// File: tb/tb_board_display_scheduler.sv
// Scoreboard bench for board_display_scheduler with a behavioural board RAM.
module tb_board_display_scheduler;
   import board_pkg::*;

   localparam int AW = 8;
   localparam logic [23:0] TB_BG = 24'h102040;
   localparam logic [23:0] TB_PAL [8] = '{
      24'h202020, 24'h00FFFF, 24'hFFFF00, 24'h800080,
      24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF8000
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i, xy_v_i, ram_we_o, ram_init;
   logic [9:0]    x_i, y_i;
   logic [7:0]    r_o, g_o, b_o;
   logic [AW-1:0] ram_addr_o;
   logic [2:0]    ram_wdata_o, ram_rdata_i;
   logic [2:0]    mem [256];

   board_display_scheduler_if #(.addr_w_p(AW)) gif ();

   board_display_scheduler dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .x_i         (x_i),
      .y_i         (y_i),
      .xy_v_i      (xy_v_i),
      .r_o         (r_o),
      .g_o         (g_o),
      .b_o         (b_o),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i),
      .game_if     (gif)
   );

   function automatic logic [2:0] init_code(int i);
      if (i < 10) return 3'(i % 8);
      else if (i == 199) return 3'd6;
      else if (i < 200) return 3'((i / 10 + i % 10) % 8);
      else return 3'd5;
   endfunction

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_code(i);
      end else if (ram_we_o) begin
         mem[ram_addr_o] <= ram_wdata_o;
      end
      ram_rdata_i <= mem[ram_addr_o];
   end

   logic [2:0]  mdl_buf [10];
   logic        mdl_lib;
   logic [23:0] px_q [$];
   logic [7:0]  addr_q [$];
   logic [2:0]  rd_q [$];
   logic [23:0] exp_px;
   int checks = 0;
   int errors = 0;

   function automatic logic [23:0] model_px(int x);
      if (mdl_lib && x >= 320 && x < 480) return TB_PAL[mdl_buf[(x - 320) / 16]];
      else return TB_BG;
   endfunction

   task automatic drive_px(int x, int y);
      xy_v_i = 1'b1;
      x_i = 10'(x);
      y_i = 10'(y);
      px_q.push_back(model_px(x));
   endtask

   task automatic end_line();
      int tgt;
      xy_v_i = 1'b0;
      px_q.push_back(24'h000000);
      tgt = (int'(y_i) == 599) ? 0 : int'(y_i) + 1;
      if (tgt >= 140 && tgt < 460) begin
         for (int c = 0; c < 10; c++) mdl_buf[c] = mem[((tgt - 140) / 16) * 10 + c];
         mdl_lib = 1'b1;
      end else begin
         mdl_lib = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1; ram_init = 1'b1; xy_v_i = 1'b0; x_i = 10'd0; y_i = 10'd0;
      gif.game_v = 1'b0; gif.game_we = 1'b0; gif.game_addr = 8'd0; gif.game_wdata = 3'd0;
      mdl_lib = 1'b0;
      for (int c = 0; c < 10; c++) mdl_buf[c] = 3'd0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({r_o, g_o, b_o, ram_addr_o, ram_we_o} !== 33'd0) begin
         errors++; $display("FAIL reset_outs got rgb=%h addr=%0d we=%b want 0", {r_o, g_o, b_o}, ram_addr_o, ram_we_o);
      end
      checks++;
      if ({gif.game_ready, gif.game_rdata_v, gif.game_rdata} !== 5'd0) begin
         errors++; $display("FAIL reset_game got ready=%b rv=%b rd=%0d want 0", gif.game_ready, gif.game_rdata_v, gif.game_rdata);
      end
      @(negedge clk);
      reset_i = 1'b0; ram_init = 1'b0;
      #1;
      checks++;
      if (gif.game_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready_after got %b want 1", gif.game_ready);
      end
   endtask

   task automatic test_fetch();
      int xs [12];
      @(negedge clk); drive_px(319, 139);
      @(negedge clk);
      exp_px = px_q.pop_front(); checks++;
      if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_x319 got %h want %h", {r_o, g_o, b_o}, exp_px); end
      drive_px(400, 139);
      @(negedge clk);
      exp_px = px_q.pop_front(); checks++;
      if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_y139 got %h want %h", {r_o, g_o, b_o}, exp_px); end
      end_line();
      for (int a = 0; a < 10; a++) addr_q.push_back(8'(a));
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            exp_px = px_q.pop_front(); checks++;
            if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_invalid got %h want %h", {r_o, g_o, b_o}, exp_px); end
         end
         checks++;
         if (ram_addr_o !== addr_q[0] || ram_we_o !== 1'b0) begin
            errors++; $display("FAIL fetch_addr got addr=%0d we=%b want addr=%0d we=0", ram_addr_o, ram_we_o, addr_q[0]);
         end
         void'(addr_q.pop_front());
      end
      repeat (6) @(negedge clk);
      for (int c = 0; c < 10; c++) xs[c] = 320 + 16 * c + 5;
      xs[10] = 319; xs[11] = 480;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (px_q.size() != 0) begin
            exp_px = px_q.pop_front(); checks++;
            if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_line140 got %h want %h", {r_o, g_o, b_o}, exp_px); end
         end
         drive_px(xs[i], 140);
      end
      @(negedge clk);
      exp_px = px_q.pop_front(); checks++;
      if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_line140_last got %h want %h", {r_o, g_o, b_o}, exp_px); end
      end_line();
      @(negedge clk);
      exp_px = px_q.pop_front(); checks++;
      if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_blank got %h want %h", {r_o, g_o, b_o}, exp_px); end
      repeat (14) @(negedge clk);
   endtask

   task automatic test_arbitration();
      @(negedge clk); drive_px(330, 141);
      @(negedge clk);
      exp_px = px_q.pop_front(); checks++;
      if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_line141 got %h want %h", {r_o, g_o, b_o}, exp_px); end
      end_line();
      gif.game_v = 1'b1; gif.game_we = 1'b1; gif.game_addr = 8'd5; gif.game_wdata = 3'd3;
      #1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) begin
            exp_px = px_q.pop_front(); checks++;
            if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_arb_blank got %h want %h", {r_o, g_o, b_o}, exp_px); end
         end
         checks++;
         if (gif.game_ready !== 1'b0) begin errors++; $display("FAIL arb_ready_low cycle %0d got %b want 0", k, gif.game_ready); end
      end
      @(negedge clk);
      checks++;
      if (gif.game_ready !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 8'd5 || ram_wdata_o !== 3'd3) begin
         errors++; $display("FAIL arb_accept got ready=%b we=%b addr=%0d wd=%0d want 1 1 5 3", gif.game_ready, ram_we_o, ram_addr_o, ram_wdata_o);
      end
      @(negedge clk); gif.game_v = 1'b0;
   endtask

   task automatic test_game_read();
      int ad [2];
      ad[0] = 199; ad[1] = 5;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         gif.game_v = 1'b1; gif.game_we = 1'b0; gif.game_addr = 8'(ad[i]);
         rd_q.push_back((i == 0) ? 3'd6 : 3'd3);
         #1;
         checks++;
         if (gif.game_ready !== 1'b1 || ram_addr_o !== 8'(ad[i]) || ram_we_o !== 1'b0) begin
            errors++; $display("FAIL rd_accept got ready=%b addr=%0d we=%b want 1 %0d 0", gif.game_ready, ram_addr_o, ram_we_o, ad[i]);
         end
         @(negedge clk); gif.game_v = 1'b0;
         checks++;
         if (gif.game_rdata_v !== 1'b1 || gif.game_rdata !== rd_q[0]) begin
            errors++; $display("FAIL rd_data got v=%b d=%0d want 1 %0d", gif.game_rdata_v, gif.game_rdata, rd_q[0]);
         end
         void'(rd_q.pop_front());
         @(negedge clk);
         checks++;
         if (gif.game_rdata_v !== 1'b0) begin errors++; $display("FAIL rd_pulse got v=%b want 0", gif.game_rdata_v); end
      end
   endtask

   task automatic test_oob();
      @(negedge clk);
      gif.game_v = 1'b1; gif.game_we = 1'b1; gif.game_addr = 8'd200; gif.game_wdata = 3'd7;
      #1;
      checks++;
      if (gif.game_ready !== 1'b1 || ram_we_o !== 1'b0) begin
         errors++; $display("FAIL oob_write got ready=%b we=%b want 1 0", gif.game_ready, ram_we_o);
      end
      @(negedge clk);
      gif.game_we = 1'b0; gif.game_addr = 8'd250;
      rd_q.push_back(3'd0);
      #1;
      checks++;
      if (gif.game_ready !== 1'b1 || ram_we_o !== 1'b0 || gif.game_rdata_v !== 1'b0) begin
         errors++; $display("FAIL oob_read_acc got ready=%b we=%b v=%b want 1 0 0", gif.game_ready, ram_we_o, gif.game_rdata_v);
      end
      @(negedge clk); gif.game_v = 1'b0;
      checks++;
      if (gif.game_rdata_v !== 1'b1 || gif.game_rdata !== rd_q[0]) begin
         errors++; $display("FAIL oob_read got v=%b d=%0d want 1 %0d", gif.game_rdata_v, gif.game_rdata, rd_q[0]);
      end
      void'(rd_q.pop_front());
   endtask

   task automatic test_below_board();
      int xs [4];
      int ys [4];
      xs[0] = 400; ys[0] = 458; xs[1] = 400; ys[1] = 459; xs[2] = 479; ys[2] = 459; xs[3] = 400; ys[3] = 460;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive_px(xs[i], ys[i]);
         @(negedge clk);
         exp_px = px_q.pop_front(); checks++;
         if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_edge y=%0d x=%0d got %h want %h", ys[i], xs[i], {r_o, g_o, b_o}, exp_px); end
         if (i == 1) continue;
         end_line();
         @(negedge clk);
         exp_px = px_q.pop_front(); checks++;
         if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_edge_blank got %h want %h", {r_o, g_o, b_o}, exp_px); end
         for (int k = 0; k < 14; k++) begin
            if (i == 2 && k < 11) begin
               checks++;
               if (ram_addr_o !== 8'd0 || gif.game_ready !== 1'b1) begin
                  errors++; $display("FAIL no_fetch got addr=%0d ready=%b want 0 1", ram_addr_o, gif.game_ready);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      @(negedge clk); drive_px(400, 150);
      @(negedge clk);
      exp_px = px_q.pop_front(); checks++;
      if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_line150 got %h want %h", {r_o, g_o, b_o}, exp_px); end
      end_line();
      repeat (5) @(negedge clk);
      void'(px_q.pop_front());
      checks++;
      if (dut.state_q !== FETCH) begin errors++; $display("FAIL mid_fetch_state got %0d want %0d", dut.state_q, FETCH); end
      reset_i = 1'b1;
      #1;
      checks++;
      if (gif.game_ready !== 1'b0 || ram_addr_o !== 8'd0) begin
         errors++; $display("FAIL rst_mid got ready=%b addr=%0d want 0 0", gif.game_ready, ram_addr_o);
      end
      @(negedge clk);
      checks++;
      if (gif.game_ready !== 1'b0 || dut.state_q !== IDLE) begin
         errors++; $display("FAIL rst_mid_idle got ready=%b state=%0d want 0 %0d", gif.game_ready, dut.state_q, IDLE);
      end
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (dut.u_buf.mem_q[c] !== 3'd0) begin errors++; $display("FAIL rst_buf[%0d] got %0d want 0", c, dut.u_buf.mem_q[c]); end
      end
      reset_i = 1'b0;
      mdl_lib = 1'b0;
      for (int c = 0; c < 10; c++) mdl_buf[c] = 3'd0;
      #1;
      checks++;
      if (gif.game_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_after got %b want 1", gif.game_ready); end
      @(negedge clk); drive_px(330, 151);
      @(negedge clk);
      exp_px = px_q.pop_front(); checks++;
      if ({r_o, g_o, b_o} !== exp_px) begin errors++; $display("FAIL px_after_rst got %h want %h", {r_o, g_o, b_o}, exp_px); end
      xy_v_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_arbitration();
      test_game_read();
      test_oob();
      test_below_board();
      test_reset_mid_fetch();
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_display_scheduler.md
Name: board_display_scheduler

Overview:
- Owns the single-port board RAM that holds the Tetris playfield. Shares it between two requesters: the display path, which has priority, and the game logic, which uses a valid/ready port.
- Once per scan line, during horizontal blanking, fetches one cell row into a line buffer. During active video it converts the pixel coordinates from vga_controller into r/g/b for that controller's colour inputs.
- Sits between vga_controller, the board RAM and the game FSM.

Parameters:
- width_p, 800, active pixels per line.
- height_p, 600, active lines per frame.
- board_w_p, 10, board width in cells.
- board_h_p, 20, board height in cells.
- cell_px_p, 16, cell edge in pixels; must be a power of two.
- board_x0_p, 320, left pixel of board.
- board_y0_p, 140, top line of board.
- bit_depth_p, 8, colour channel width.

Ports:
- clk_i  in  1  pixel clock.
- reset_i  in  1  synchronous active-high reset.
- x_i  in  $clog2(width_p)  pixel x from vga_controller.
- y_i  in  $clog2(height_p)  pixel y from vga_controller.
- xy_v_i  in  1  pixel coordinate valid.
- r_o, g_o, b_o  out  bit_depth_p each  pixel colour to vga_controller.
- ram_addr_o  out  A=$clog2(board_w_p*board_h_p)  RAM address.
- ram_we_o  out  1  RAM write enable.
- ram_wdata_o  out  3  cell code to write.
- ram_rdata_i  in  3  read data, one cycle after the address.
- game_v_i  in  1  game request valid.
- game_ready_o  out  1  game request accepted.
- game_we_i  in  1  1 = write, 0 = read.
- game_addr_i  in  A  cell index, row*board_w_p+col.
- game_wdata_i  in  3  cell code.
- game_rdata_o  out  3  read result.
- game_rdata_v_o  out  1  read result valid.

Behaviour:
- Reset values: r_o/g_o/b_o=0, ram_we_o=0, ram_addr_o=0, game_ready_o=0, game_rdata_v_o=0, game_rdata_o=0. FSM is in IDLE and all line-buffer entries are 0.
- game_ready_o is forced 0 while reset_i=1.
- Fetch trigger: a falling edge of xy_v_i, detected with a registered copy of xy_v_i.
  - Target line is 0 if the last valid y_i was height_p-1; otherwise it is that y_i+1.
  - The last valid y_i is held in a register.
- FSM IDLE:
  - On trigger, if the target line is in [board_y0_p, board_y0_p+board_h_p*cell_px_p), go to FETCH.
  - The cell row is (target-board_y0_p)>>log2(cell_px_p).
  - If the target line is outside that range, clear the line_in_board flag and stay in IDLE.
- FSM FETCH:
  - Issues reads at addresses row*board_w_p+c for c=0..board_w_p-1, one per cycle.
  - Captures ram_rdata_i into buffer[c] one cycle after issuing address c.
  - After the last address, goes to DRAIN.
- FSM DRAIN: captures the final word, sets line_in_board, returns to IDLE. A full fetch is board_w_p+1 cycles, which is well inside the 224-cycle horizontal blank.
- Arbitration:
  - game_ready_o = (state==IDLE) & ~trigger & ~reset_i. The display wins simultaneous events.
  - A game request that is not accepted must be held stable by the requester.
  - On accept, the game address is driven to ram_addr_o the same cycle. ram_we_o=game_we_i.
- Game reads: game_rdata_v_o pulses 1 the cycle after acceptance, with game_rdata_o=ram_rdata_i.
- Out-of-range game address (>= board_w_p*board_h_p):
  - The request is accepted, but ram_we_o is held 0.
  - A read returns 0 with game_rdata_v_o still pulsed.
- Pixel path: registered, 1-cycle latency.
  - If xy_v_i=0, output 0.
  - If xy_v_i=1, line_in_board=1 and x_i is in [board_x0_p, board_x0_p+board_w_p*cell_px_p): col=(x_i-board_x0_p)>>log2(cell_px_p), colour=PALETTE[buffer[col]].
  - Otherwise colour=BG_COLOUR.
  - Code 0 maps to the empty-cell colour.
- Coherency: game writes landing between a row's fetch and its display appear on the next frame. Tearing is accepted.
- Reset mid-fetch: abort to IDLE and clear the buffer. The current line then shows as background.

Decomposition:
- Package board_pkg holds:
  - the cell_code_t 3-bit typedef;
  - the PALETTE[8] array of 24-bit RGB constants;
  - BG_COLOUR and EMPTY_COLOUR;
  - the fsm_state_e enum (IDLE, FETCH, DRAIN).
- One natural sub-module is board_line_buffer: a board_w_p x 3-bit register array with a write port and a combinational read port.

Test Plan:
- Reset asserted mid-FETCH: FSM returns to IDLE, the buffer reads all 0, and game_ready_o is 0 during reset and 1 on the first cycle after.
- RAM preloaded with cell(row 0, c)=c%8, and the xy_v_i falling edge at y=139:
  - ram_addr_o shows 0..9 on consecutive cycles;
  - on line 140, x=320+16*c+5 gives PALETTE[c%8] one cycle later.
- game_v_i held high, write to addr 5 with code 3, asserted in the same cycle as the trigger:
  - game_ready_o is 0 for 12 cycles;
  - the write is then accepted with ram_we_o=1 and ram_addr_o=5.
- Game read of addr 199 holding code 6: game_rdata_v_o=1 one cycle after accept, with game_rdata_o=6.
- Game write to addr 200 and read of addr 250: ram_we_o stays 0, the read returns 0, and game_rdata_v_o pulses.
- Pixel checks:
  - x=319 or y=139 gives BG_COLOUR;
  - y=460, the first line below the board, gives BG_COLOUR with no fetch issued;
  - xy_v_i=0 gives r/g/b=0.
